// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_state_t;

    localparam int MUL_N  = 32;
    localparam int MUL_CW = $clog2(MUL_N);

endpackage

// File: rtl/shift_left_logical.sv
// 32-bit logical left barrel shifter: out = in << shamt, zero fill.
module shift_left_logical (
    input  logic [31:0] in,
    input  logic [4:0]  shamt,
    output logic [31:0] out
);

    // One candidate per shift amount; the matching one is selected.
    always_comb begin
        out = '0;
        for (int i = 0; i < 32; i++) begin
            if (shamt == 5'(i)) begin
                out = in << i;
            end
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative shift-and-add multiplier returning the low N bits of a*b.
// Optional early exit when the remaining multiplier bits are zero: SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int N = MUL_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] product,
    output mul_state_t   o_dbg_state
);

    localparam int CW = $clog2(N);

`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready only looks at out_ready while a result is waiting (S_DONE).
    mul_state_t    r_state;
    mul_state_t    w_next_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  w_shifted;
    logic          w_accept;
    logic          w_skip;
    logic          w_last_cnt;

    shift_left_logical u_shift (
        .in    (r_a),
        .shamt (r_cnt),
        .out   (w_shifted)
    );

    assign w_accept   = in_valid && in_ready;
    assign w_skip     = EARLY_EXIT && (r_b == '0);
    assign w_last_cnt = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_skip || w_last_cnt) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = in_valid ? S_RUN : S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
        out_valid   = (r_state == S_DONE);
        product     = r_acc;
        o_dbg_state = r_state;
    end

    // Datapath: load on accept, otherwise one conditional add per RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if ((r_state == S_RUN) && !w_skip) begin
            if (r_b[0]) begin
                r_acc <= r_acc + w_shifted;
            end
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule
